// File: rtl/divider_unsigned_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
package divider_unsigned_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder from the functional-unit library.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g, p;
  logic [8:0] c;
  logic       pp;

  // Each carry is expanded as a flat sum of generate/propagate products.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/divider_unsigned.sv
// Sequential restoring divider: one quotient bit per cycle, start/done handshake.
module divider_unsigned
  import divider_unsigned_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  // The ninth remainder bit is always zero after a restoring step, so it is not stored.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             ge;

  assign t  = {r_q, q_q[WIDTH-1]};
  assign ge = t[WIDTH] | cout;

  cla_8bit u_sub (
    .a    (t[WIDTH-1:0]),
    .b    (~d_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (B != '0) begin
            q_d     = A;
            r_d     = '0;
            d_d     = B;
            cnt_d   = 3'(WIDTH - 1);
            state_d = CALC;
          end else begin
            quot_d  = DIV0_QUOT;
            rem_d   = A;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        r_d   = ge ? diff : t[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign Quot        = quot_q;
  assign Rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule
